// File: rtl/mux8_scan_capture_if.sv
// ---------------------------------------------------------------------------
// mux8_scan_capture_if
//
// Purpose: groups the scan request, the mux select/output pair and the
// captured-byte result of mux8_scan_capture into one bundle.
//
// Signals:
//   start   scan request (from controller)
//   Y       8-to-1 mux output (from the external mux)
//   S0..S2  mux select lines, S0 = LSB (to the external mux)
//   data    captured byte, bit k = Y while select = k
//   valid   one-cycle strobe, data updated this cycle
//   busy    scan in progress
//   parity  even parity of data (only when MUXSEQ_PARITY_EN is defined)
//
// Modports:
//   master  controller / mux side: drives start and Y, observes the rest
//   slave   the scan-capture block itself
//
// Build option: MUXSEQ_PARITY_EN adds the parity signal.
// ---------------------------------------------------------------------------
interface mux8_scan_capture_if;
    logic       start;
    logic       Y;
    logic       S0;
    logic       S1;
    logic       S2;
    logic [7:0] data;
    logic       valid;
    logic       busy;
`ifdef MUXSEQ_PARITY_EN
    logic       parity;

    modport master (
        output start,
        output Y,
        input  S0,
        input  S1,
        input  S2,
        input  data,
        input  valid,
        input  busy,
        input  parity
    );

    modport slave (
        input  start,
        input  Y,
        output S0,
        output S1,
        output S2,
        output data,
        output valid,
        output busy,
        output parity
    );
`else
    modport master (
        output start,
        output Y,
        input  S0,
        input  S1,
        input  S2,
        input  data,
        input  valid,
        input  busy
    );

    modport slave (
        input  start,
        input  Y,
        output S0,
        output S1,
        output S2,
        output data,
        output valid,
        output busy
    );
`endif
endinterface

// File: rtl/mux8_scan_capture.sv
// ---------------------------------------------------------------------------
// mux8_scan_capture
//
// Purpose: sequential driver and capture stage for an 8-to-1 mux. On a
// start request the select lines step through codes 0..7; each code is held
// for SETTLE cycles and Y is sampled on the last edge of each slot. The
// eight samples are presented as one byte with a one-cycle valid strobe.
//
// Parameters:
//   SETTLE   cycles each select code is held before Y is sampled (1..15)
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   bus      mux8_scan_capture_if.slave
//              in : start, Y
//              out: S0, S1, S2, data[7:0], valid, busy, parity (optional)
//
// Build option: MUXSEQ_PARITY_EN -- when defined, bus.parity carries the
// even parity (XOR of all bits) of data, registered together with data.
//
// Timing: start accepted at edge E0 -> select k driven from E0+k*SETTLE,
// bit k sampled at E0+(k+1)*SETTLE, valid/data after E0+8*SETTLE.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module mux8_scan_capture #(
    parameter int unsigned SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mux8_scan_capture_if.slave bus
);

    // Settle counter counts down SETTLE-1 .. 0; the sample is taken on the
    // edge where it reads 0, so each code is held exactly SETTLE cycles.
    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);
    localparam logic [2:0] LAST_SEL   = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t      state_reg,  state_next;
    logic [2:0]  sel_reg,    sel_next;
    logic [3:0]  cnt_reg,    cnt_next;
    logic [6:0]  shadow_reg, shadow_next;
    logic [7:0]  data_reg,   data_next;
    logic        valid_reg,  valid_next;
    logic        busy_reg,   busy_next;
    logic        capture_en;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            sel_reg    <= '0;
            cnt_reg    <= '0;
            shadow_reg <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            cnt_reg    <= cnt_next;
            shadow_reg <= shadow_next;
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            busy_reg   <= busy_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        busy_next  = busy_reg;
        capture_en = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                sel_next  = '0;
                busy_next = 1'b0;
                if (bus.start) begin
                    state_next = ST_SCAN;
                    cnt_next   = CNT_RELOAD;
                    busy_next  = 1'b1;
                end
            end

            ST_SCAN: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else if (sel_reg != LAST_SEL) begin
                    // Slot boundary for codes 0..6: bit goes to the shadow
                    // register, select advances.
                    capture_en = 1'b1;
                    sel_next   = sel_reg + 3'd1;
                    cnt_next   = CNT_RELOAD;
                end else begin
                    // Final slot: bit 7 is taken straight from Y so the byte
                    // is complete on this same edge.
                    data_next  = {bus.Y, shadow_reg};
                    valid_next = 1'b1;
                    sel_next   = '0;
                    if (bus.start) begin
                        // Back-to-back scan: no idle gap, busy stays high.
                        cnt_next  = CNT_RELOAD;
                        busy_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                        busy_next  = 1'b0;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                sel_next   = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Shadow register: one enable per bit, decoded from the current select.
    // Stale bits from an earlier scan are always overwritten before use.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_shadow
            assign shadow_next[gi] = (capture_en && (sel_reg == 3'(gi)))
                                     ? bus.Y : shadow_reg[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Optional parity, updated on the same edge as data.
    // -----------------------------------------------------------------------
`ifdef MUXSEQ_PARITY_EN
    logic parity_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_reg <= 1'b0;
        end else if (valid_next) begin
            parity_reg <= ^data_next;
        end
    end

    assign bus.parity = parity_reg;
`endif

    // -----------------------------------------------------------------------
    // Outputs (all registered)
    // -----------------------------------------------------------------------
    assign bus.S0    = sel_reg[0];
    assign bus.S1    = sel_reg[1];
    assign bus.S2    = sel_reg[2];
    assign bus.data  = data_reg;
    assign bus.valid = valid_reg;
    assign bus.busy  = busy_reg;

endmodule

// File: tb/tb_mux8_scan_capture.sv
// ---------------------------------------------------------------------------
// tb_mux8_scan_capture
//
// Two instances: SETTLE=1 (index 0) and SETTLE=3 (index 1). Each instance
// is fed by a modelled 8-to-1 mux whose inputs are mux_in[i]. A timing
// model (scan phase counted in cycles since the accepted start) predicts
// select, busy, valid, data and parity each cycle; directed checks cover
// the listed scenarios and a random phase follows.
// Build option: MUXSEQ_PARITY_EN (must match the RTL build).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux8_scan_capture;

    logic       clk = 1'b0;
    logic       rst_drv   [2];
    logic       start_drv [2];
    logic [7:0] mux_in    [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux8_scan_capture_if bus1 ();
    mux8_scan_capture_if bus3 ();

    assign bus1.start = start_drv[0];
    assign bus3.start = start_drv[1];
    assign bus1.Y     = mux_in[0][{bus1.S2, bus1.S1, bus1.S0}];
    assign bus3.Y     = mux_in[1][{bus3.S2, bus3.S1, bus3.S0}];

    mux8_scan_capture #(.SETTLE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_drv[0]),
        .bus   (bus1.slave)
    );

    mux8_scan_capture #(.SETTLE(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_drv[1]),
        .bus   (bus3.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model. ph = cycles since the edge that accepted start
    // (-1 when idle). The select in use is ph/SETTLE; bit k is taken from
    // the mux input at the edge where ph reaches (k+1)*SETTLE.
    // -----------------------------------------------------------------------
    int         ph        [2] = '{-1, -1};
    logic [7:0] bits      [2];
    logic [7:0] exp_data  [2] = '{8'h00, 8'h00};
    logic       exp_valid [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int         p;
            int         s;
            logic [7:0] b;
            logic [7:0] d;
            logic       v;
            s = (i == 0) ? 1 : 3;
            p = ph[i];
            b = bits[i];
            d = exp_data[i];
            v = 1'b0;
            if (!rst_drv[i]) begin
                p = -1;
                b = 8'h00;
                d = 8'h00;
            end else if (p < 0) begin
                if (start_drv[i]) p = 0;
            end else begin
                p = p + 1;
                if (p % s == 0) begin
                    b[p / s - 1] = mux_in[i][p / s - 1];
                    if (p == 8 * s) begin
                        d = b;
                        v = 1'b1;
                        p = start_drv[i] ? 0 : -1;
                    end
                end
            end
            ph[i]        <= p;
            bits[i]      <= b;
            exp_data[i]  <= d;
            exp_valid[i] <= v;
        end
    end

    // -----------------------------------------------------------------------
    // Per-cycle comparison on the falling edge.
    // -----------------------------------------------------------------------
    logic check_en  = 1'b0;
    int   valid_cnt [2] = '{0, 0};
    int   busy_cnt  [2] = '{0, 0};

    task automatic check_one(input int i, input logic [2:0] sel, input logic busy,
                             input logic valid, input logic [7:0] data);
        int s;
        s = (i == 0) ? 1 : 3;
        check($sformatf("sel[%0d]", i),   32'(sel),   (ph[i] < 0) ? 32'd0 : 32'(ph[i] / s));
        check($sformatf("busy[%0d]", i),  32'(busy),  32'(ph[i] >= 0));
        check($sformatf("valid[%0d]", i), 32'(valid), 32'(exp_valid[i]));
        check($sformatf("data[%0d]", i),  32'(data),  32'(exp_data[i]));
        if (valid) valid_cnt[i]++;
        if (busy)  busy_cnt[i]++;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_one(0, {bus1.S2, bus1.S1, bus1.S0}, bus1.busy, bus1.valid, bus1.data);
            check_one(1, {bus3.S2, bus3.S1, bus3.S0}, bus3.busy, bus3.valid, bus3.data);
`ifdef MUXSEQ_PARITY_EN
            check("parity[0]", 32'(bus1.parity), 32'(^exp_data[0]));
            check("parity[1]", 32'(bus3.parity), 32'(^exp_data[1]));
`endif
        end
    end

    // Main actions happen 1ns after the falling edge, after the monitor.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One SETTLE=1 scan of byte v with directed result checks.
    task automatic scan1(input logic [7:0] v, input logic exp_par);
        int vs;
        int bs;
        mux_in[0]    = v;
        vs           = valid_cnt[0];
        bs           = busy_cnt[0];
        start_drv[0] = 1'b1;
        tick();
        start_drv[0] = 1'b0;
        repeat (8) tick();
        check("scan1_valid", 32'(bus1.valid), 32'd1);
        check("scan1_data",  32'(bus1.data),  32'(v));
`ifdef MUXSEQ_PARITY_EN
        check("scan1_parity", 32'(bus1.parity), 32'(exp_par));
`else
        if (exp_par === 1'bx) $display("note: unused parity argument");
`endif
        repeat (2) tick();
        check("scan1_valid_count", 32'(valid_cnt[0] - vs), 32'd1);
        check("scan1_busy_cycles", 32'(busy_cnt[0] - bs), 32'd8);
    endtask

    initial begin
        int vs;
        int bs;
        rst_drv   = '{1'b0, 1'b0};
        start_drv = '{1'b1, 1'b1};
        mux_in[0] = 8'($urandom);
        mux_in[1] = 8'($urandom);

        // Reset held 3 cycles with start high: nothing may start.
        repeat (3) @(posedge clk);
        tick();
        check_en = 1'b1;
        check("rst_data",  32'(bus1.data),  32'h00);
        check("rst_valid", 32'(bus1.valid), 32'd0);
        check("rst_busy",  32'(bus1.busy),  32'd0);
        check("rst_sel",   32'({bus1.S2, bus1.S1, bus1.S0}), 32'd0);
        check("rst_busy3", 32'(bus3.busy),  32'd0);
        rst_drv   = '{1'b1, 1'b1};
        start_drv = '{1'b0, 1'b0};
        repeat (2) tick();

        // Basic scans and the parity patterns.
        scan1(8'hA5, 1'b0);
        scan1(8'h07, 1'b1);
        scan1(8'h00, 1'b0);

        // SETTLE=3: inputs scrambled except on each slot's sampling edge.
        mux_in[1]    = 8'h3C;
        start_drv[1] = 1'b1;
        tick();
        start_drv[1] = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            mux_in[1] = (c % 3 == 0) ? 8'h3C : 8'($urandom);
            tick();
        end
        check("settle3_valid", 32'(bus3.valid), 32'd1);
        check("settle3_data",  32'(bus3.data),  32'h3C);
        repeat (2) tick();

        // Start pulsed mid-scan is ignored.
        mux_in[0]    = 8'($urandom);
        vs           = valid_cnt[0];
        start_drv[0] = 1'b1;
        tick();
        start_drv[0] = 1'b0;
        repeat (3) tick();
        start_drv[0] = 1'b1;
        tick();
        start_drv[0] = 1'b0;
        repeat (12) tick();
        check("ignored_start_valids", 32'(valid_cnt[0] - vs), 32'd1);

        // Start held high: back-to-back scans alternating FF / 00.
        vs           = valid_cnt[0];
        bs           = busy_cnt[0];
        mux_in[0]    = 8'hFF;
        start_drv[0] = 1'b1;
        tick();
        for (int c = 1; c <= 32; c++) begin
            mux_in[0] = (((c - 1) / 8) % 2 == 1) ? 8'h00 : 8'hFF;
            tick();
            if (c % 8 == 0) begin
                check("b2b_valid", 32'(bus1.valid), 32'd1);
                check("b2b_data",  32'(bus1.data), (((c / 8) % 2) == 1) ? 32'hFF : 32'h00);
            end
        end
        check("b2b_busy_cycles", 32'(busy_cnt[0] - bs), 32'd33);
        check("b2b_valids",      32'(valid_cnt[0] - vs), 32'd4);
        start_drv[0] = 1'b0;
        repeat (10) tick();

        // Reset mid-scan discards the partial result.
        mux_in[0]    = 8'hFF;
        start_drv[0] = 1'b1;
        tick();
        start_drv[0] = 1'b0;
        repeat (4) tick();
        rst_drv[0] = 1'b0;
        tick();
        check("midrst_data", 32'(bus1.data), 32'h00);
        check("midrst_busy", 32'(bus1.busy), 32'd0);
        check("midrst_sel",  32'({bus1.S2, bus1.S1, bus1.S0}), 32'd0);
        rst_drv[0] = 1'b1;
        vs = valid_cnt[0];
        repeat (12) tick();
        check("midrst_no_valid", 32'(valid_cnt[0] - vs), 32'd0);

        // Random phase on both instances.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                start_drv[i] = ($urandom_range(0, 3) == 0);
                mux_in[i]    = 8'($urandom);
                rst_drv[i]   = ($urandom_range(0, 63) != 0);
            end
            tick();
        end
        rst_drv   = '{1'b1, 1'b1};
        start_drv = '{1'b0, 1'b0};
        repeat (30) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
